// File: rtl/sha256_bus_responder_if.sv
// Register-bus bundle between a bus initiator and sha256_bus_responder:
// one access per cycle while cs is high, registered read_data/error response.
interface sha256_bus_responder_if;
   logic        cs;
   logic        we;
   logic [7:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        error;

   modport master (
      output cs, we, address, write_data,
      input  read_data, error
   );

   modport slave (
      input  cs, we, address, write_data,
      output read_data, error
   );
endinterface

// File: rtl/sha256_bus_responder.sv
// Register-bus front end for the SHA-256 core: block/digest registers, init/next pulses, status.
// Optional macro SHA_BUS_WRITE_LOCK_EN: reject BLOCKn writes while an operation is in flight.
module sha256_bus_responder (
   input  logic                    clk,
   input  logic                    reset,
   sha256_bus_responder_if.slave   bus,
   output logic                    core_init,
   output logic                    core_next,
   output logic [511:0]            core_block,
   input  logic                    core_ready,
   input  logic [255:0]            core_digest,
   input  logic                    core_digest_valid
);

   localparam logic [31:0] CORE_NAME0   = 32'h73686132;
   localparam logic [31:0] CORE_NAME1   = 32'h2d323536;
   localparam logic [31:0] CORE_VERSION = 32'h00000001;
   localparam logic [7:0]  ADDR_CTRL    = 8'h08;
   localparam logic [7:0]  ADDR_STATUS  = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_BUSY     = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        valid_q, valid_d;
   logic [31:0] block_q  [16];
   logic [31:0] block_d  [16];
   logic [31:0] digest_q [8];
   logic [31:0] digest_d [8];
   logic [31:0] read_data_q, read_data_d;
   logic        error_q, error_d;
   logic        core_init_q, core_init_d;
   logic        core_next_q, core_next_d;

   logic        is_ident;
   logic        is_block;
   logic        is_digest;

   function automatic logic [31:0] ident_word(input logic [1:0] idx);
      case (idx)
         2'd0:    ident_word = CORE_NAME0;
         2'd1:    ident_word = CORE_NAME1;
         2'd2:    ident_word = CORE_VERSION;
         default: ident_word = 32'd0;
      endcase
   endfunction

   assign is_ident  = (bus.address < 8'd3);
   assign is_block  = (bus.address[7:4] == 4'h1);
   assign is_digest = (bus.address[7:3] == 5'h04);

   // Bus decode, command issue and operation tracking.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      block_d     = block_q;
      digest_d    = digest_q;
      read_data_d = read_data_q;
      error_d     = 1'b0;
      core_init_d = 1'b0;
      core_next_d = 1'b0;

      if (bus.cs && !bus.we) begin
         if (is_ident) begin
            read_data_d = ident_word(bus.address[1:0]);
         end else if (bus.address == ADDR_CTRL) begin
            read_data_d = 32'd0;
         end else if (bus.address == ADDR_STATUS) begin
            // Ready comes from our own FSM so a poll right after a command never sees stale ready.
            read_data_d = {30'd0, valid_q, (state_q == ST_IDLE)};
         end else if (is_block) begin
            read_data_d = block_q[bus.address[3:0]];
         end else if (is_digest) begin
            read_data_d = digest_q[bus.address[2:0]];
         end else begin
            read_data_d = 32'd0;
            error_d     = 1'b1;
         end
      end else if (bus.cs && bus.we) begin
         if (bus.address == ADDR_CTRL) begin
            if (state_q == ST_IDLE) begin
               if (bus.write_data[0]) begin
                  core_init_d = 1'b1;
               end else if (bus.write_data[1]) begin
                  core_next_d = 1'b1;
               end else begin
                  core_init_d = 1'b0;
               end
            end else begin
               error_d = 1'b1;
            end
         end else if (is_block) begin
`ifdef SHA_BUS_WRITE_LOCK_EN
            if (state_q != ST_IDLE) begin
               error_d = 1'b1;
            end else begin
               block_d[bus.address[3:0]] = bus.write_data;
            end
`else
            block_d[bus.address[3:0]] = bus.write_data;
`endif
         end else begin
            error_d = 1'b1;
         end
      end else begin
         read_data_d = read_data_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (core_init_d || core_next_d) begin
               state_d = ST_WAIT_ACK;
               valid_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT_ACK: begin
            if (!core_ready) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_WAIT_ACK;
            end
         end
         ST_BUSY: begin
            if (core_ready) begin
               state_d = ST_IDLE;
               if (core_digest_valid) begin
                  for (int i = 0; i < 8; i++) begin
                     digest_d[i] = core_digest[255 - 32*i -: 32];
                  end
                  valid_d = 1'b1;
               end else begin
                  valid_d = valid_q;
               end
            end else begin
               state_d = ST_BUSY;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         valid_q     <= 1'b0;
         read_data_q <= 32'd0;
         error_q     <= 1'b0;
         core_init_q <= 1'b0;
         core_next_q <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            block_q[i] <= 32'd0;
         end
         for (int i = 0; i < 8; i++) begin
            digest_q[i] <= 32'd0;
         end
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         read_data_q <= read_data_d;
         error_q     <= error_d;
         core_init_q <= core_init_d;
         core_next_q <= core_next_d;
         for (int i = 0; i < 16; i++) begin
            block_q[i] <= block_d[i];
         end
         for (int i = 0; i < 8; i++) begin
            digest_q[i] <= digest_d[i];
         end
      end
   end

   // Block registers packed word0-first onto the core's wide port.
   always_comb begin
      core_block = 512'd0;
      for (int i = 0; i < 16; i++) begin
         core_block[511 - 32*i -: 32] = block_q[i];
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.error     = error_q;
   assign core_init     = core_init_q;
   assign core_next     = core_next_q;

endmodule
